riscv_dmi_arbiter: RTL and testbench
====================================

# riscv_dmi_arbiter

Shares the single Debug Module Interface (DMI) request/response port of the debug module between NUM_REQ independent requesters, for example the JTAG DTM and a memory-mapped system-bus debug bridge. It sits between the requesters and the DM. It grants one requester at a time using round-robin, registers the granted request, and holds the grant until the matching response has been delivered. An optional response timeout returns a failure so that a hung DM cannot lock out the other requesters.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 0: maximum clk_i cycles spent in RESP before a synthesized failure response; 0 disables the timeout.

Ports:
- clk_i  in  1  DM-domain clock; all logic samples on the rising edge.
- trst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accepted.
- req_addr_i  in  NUM_REQ x riscv_dm_pkg::DMI_ADDR_WIDTH  per-requester address.
- req_data_i  in  NUM_REQ x riscv_dm_pkg::DMI_DATA_WIDTH  per-requester write data.
- req_op_i  in  NUM_REQ x riscv_dm_pkg::DMI_OP_WIDTH  per-requester op.
- resp_valid_o  out  NUM_REQ  per-requester response valid.
- resp_ready_i  in  NUM_REQ  per-requester response ready.
- resp_data_o  out  riscv_dm_pkg::DMI_DATA_WIDTH  response data, shared by all requesters; qualified by resp_valid_o.
- resp_op_o  out  riscv_dm_pkg::DMI_OP_WIDTH  response op, shared by all requesters.
- dm_req_valid_o / dm_req_ready_i / dm_req_addr_o / dm_req_data_o / dm_req_op_o: DM-side request channel.
- dm_resp_valid_i / dm_resp_ready_o / dm_resp_data_i / dm_resp_op_i: DM-side response channel.
- grant_o  out  $clog2(NUM_REQ)  index of the current or last granted requester (debug visibility).
- busy_o  out  1  1 whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, REQ, RESP, DRAIN.
- IDLE:
  - The winner is the first requester with req_valid_i set, searching from the round-robin pointer rr_ptr upward with wrap-around.
  - req_ready_o[winner] = 1 combinationally in the same cycle; all other req_ready_o bits stay 0.
  - On that edge the arbiter captures addr/data/op into registers, sets grant = winner, and moves to REQ.
- REQ:
  - dm_req_valid_o = 1 and dm_req_* are driven from the registers.
  - The payload is held stable until dm_req_ready_i = 1, then the FSM moves to RESP.
- RESP:
  - dm_resp_ready_o = resp_ready_i[grant].
  - resp_valid_o[grant] = dm_resp_valid_i; resp_data_o and resp_op_o are passed through from the DM.
  - On dm_resp_valid_i & resp_ready_i[grant]: go to IDLE and set rr_ptr = (grant+1) mod NUM_REQ.
- Timeout (TIMEOUT_CYCLES > 0):
  - A counter clears on entry to RESP and increments every cycle spent in RESP.
  - When count == TIMEOUT_CYCLES with no DM response, resp_valid_o[grant] = 1 with resp_op_o = RD_OP_FAILED and resp_data_o = 0.
  - Once the requester accepts that synthesized response, the FSM moves to DRAIN.
- DRAIN:
  - dm_resp_ready_o = 1 and all resp_valid_o bits = 0.
  - The first dm_resp_valid_i is discarded; the FSM then moves to IDLE and advances rr_ptr.
- Simultaneous events:
  - A real DM response arriving in the same cycle the timeout fires takes precedence; no failure is synthesized.
  - A new req_valid_i while the FSM is not IDLE is stalled (req_ready_o = 0). Pending requesters are never dropped.
- Non-granted requesters always see resp_valid_o = 0.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant 0, counter 0, captured payload registers 0.
- Outputs during reset: all req_ready_o and resp_valid_o 0, dm_req_valid_o 0, dm_resp_ready_o 0, busy_o 0.
- Latency: a request accepted at edge N gives dm_req_valid_o = 1 in cycle N+1.
- Minimum request-to-request turnaround is 3 cycles (IDLE, REQ, RESP) with zero-wait handshakes.
- Reset asserted mid-transaction aborts it immediately with no response to the requester. The DM must also be reset; a late DM response after reset is ignored, since the FSM is in IDLE with dm_resp_ready_o = 0.
- Starvation bound: a requester holding req_valid_i is granted within NUM_REQ-1 transactions.

## Structure
- Add to riscv_dm_pkg: dmi_arb_state_t (2-bit enum), RD_OP_FAILED (= 2) if not already defined, and a dmi_req_t struct {addr, data, op}.
- Sub-module riscv_dmi_rr_pick: combinational round-robin search; inputs valid vector and rr_ptr; outputs winner index and any_valid.

## Test plan
- Single request: requester 1 sends a read to addr 0x11. Expect dm_req_addr_o = 0x11 one cycle after req_ready_o[1]. The DM responds data 0xDEADBEEF, op 0. Expect resp_valid_o[1] with that data and resp_valid_o[0] = 0.
- Simultaneous requests: both requesters valid from reset. Expect grant order 0, 1, 0, 1 over four back-to-back transactions.
- Backpressure: dm_req_ready_i held low for 5 cycles. Expect dm_req_* stable and requester 1 stalled until requester 0's response completes.
- Timeout: TIMEOUT_CYCLES = 8, the DM never responds. Expect resp_op_o = 2 and data 0 after 8 RESP cycles. A DM response injected afterwards is drained and not forwarded.
- Response backpressure: resp_ready_i[0] low for 3 cycles. Expect dm_resp_ready_o low during those cycles and the response delivered unchanged.
- Reset mid-REQ: assert trst_i. Expect all outputs 0 asynchronously; after release, a new request is granted normally.

Source files
------------

// File: rtl/riscv_dm_pkg.sv
// DMI widths, op encodings and arbiter types shared by the debug module and the DMI arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package riscv_dm_pkg;

   localparam int DMI_ADDR_WIDTH = 7;
   localparam int DMI_DATA_WIDTH = 32;
   localparam int DMI_OP_WIDTH   = 2;

   // Request ops
   localparam logic [DMI_OP_WIDTH-1:0] DTM_NOP   = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] DTM_READ  = 2'd1;
   localparam logic [DMI_OP_WIDTH-1:0] DTM_WRITE = 2'd2;

   // Response ops
   localparam logic [DMI_OP_WIDTH-1:0] DTM_SUCCESS  = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] RD_OP_FAILED = 2'd2;
   localparam logic [DMI_OP_WIDTH-1:0] DTM_BUSY     = 2'd3;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_REQ   = 2'd1,
      ARB_RESP  = 2'd2,
      ARB_DRAIN = 2'd3
   } dmi_arb_state_t;

   typedef struct packed {
      logic [DMI_ADDR_WIDTH-1:0] addr;
      logic [DMI_DATA_WIDTH-1:0] data;
      logic [DMI_OP_WIDTH-1:0]   op;
   } dmi_req_t;

   // Next round-robin position after idx in a ring of n entries.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/riscv_dmi_rr_pick.sv
// Round-robin search: first set bit of valid_i starting at rr_ptr_i, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module riscv_dmi_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IW-1:0]      rr_ptr_i,
   output logic [IW-1:0]      winner_o,
   output logic               any_valid_o
);

   int idx;

   // Walk the ring from the pointer and latch the first requester found.
   always_comb begin
      winner_o    = '0;
      any_valid_o = 1'b0;
      idx         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr_i) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!any_valid_o && valid_i[IW'(idx)]) begin
            any_valid_o = 1'b1;
            winner_o    = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/riscv_dmi_arbiter.sv
// Shares one DMI request/response port of the DM between NUM_REQ requesters, round-robin, one transaction in flight.
// Latency: request accepted at edge N is presented to the DM in cycle N+1; 3-cycle minimum turnaround.
// Backpressure: losers and all requesters outside IDLE see req_ready_o=0; DM response waits on the granted resp_ready_i.
module riscv_dmi_arbiter
   import riscv_dm_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                                      clk_i,
   input  logic                                      trst_i,

   input  logic [NUM_REQ-1:0]                        req_valid_i,
   output logic [NUM_REQ-1:0]                        req_ready_o,
   input  logic [NUM_REQ-1:0][DMI_ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [NUM_REQ-1:0][DMI_DATA_WIDTH-1:0]    req_data_i,
   input  logic [NUM_REQ-1:0][DMI_OP_WIDTH-1:0]      req_op_i,

   output logic [NUM_REQ-1:0]                        resp_valid_o,
   input  logic [NUM_REQ-1:0]                        resp_ready_i,
   output logic [DMI_DATA_WIDTH-1:0]                 resp_data_o,
   output logic [DMI_OP_WIDTH-1:0]                   resp_op_o,

   output logic                                      dm_req_valid_o,
   input  logic                                      dm_req_ready_i,
   output logic [DMI_ADDR_WIDTH-1:0]                 dm_req_addr_o,
   output logic [DMI_DATA_WIDTH-1:0]                 dm_req_data_o,
   output logic [DMI_OP_WIDTH-1:0]                   dm_req_op_o,

   input  logic                                      dm_resp_valid_i,
   output logic                                      dm_resp_ready_o,
   input  logic [DMI_DATA_WIDTH-1:0]                 dm_resp_data_i,
   input  logic [DMI_OP_WIDTH-1:0]                   dm_resp_op_i,

   output logic [$clog2(NUM_REQ)-1:0]                grant_o,
   output logic                                      busy_o
);

   localparam int             GW     = $clog2(NUM_REQ);
   localparam bit             TO_EN  = (TIMEOUT_CYCLES > 0);
   localparam int             CW     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT_CYCLES);

   dmi_arb_state_t state_q, state_d;
   dmi_req_t       req_q;
   logic [GW-1:0]  rr_ptr_q;
   logic [GW-1:0]  grant_q;
   logic [GW-1:0]  grant_inc;
   logic [GW-1:0]  winner;
   logic           any_valid;
   logic [CW-1:0]  cnt_q;
   logic           timed_out;
   logic           capture;
   logic           advance;

   riscv_dmi_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (GW)
   ) u_rr_pick (
      .valid_i     (req_valid_i),
      .rr_ptr_i    (rr_ptr_q),
      .winner_o    (winner),
      .any_valid_o (any_valid)
   );

   assign grant_inc     = GW'(rr_next(32'(grant_q), NUM_REQ));
   assign timed_out     = TO_EN && (cnt_q == TO_VAL);
   assign dm_req_addr_o = req_q.addr;
   assign dm_req_data_o = req_q.data;
   assign dm_req_op_o   = req_q.op;
   assign grant_o       = grant_q;
   assign busy_o        = (state_q != ARB_IDLE);

   // Next-state and handshake decode; a real DM response always wins over a synthesized failure.
   always_comb begin
      state_d         = state_q;
      req_ready_o     = '0;
      resp_valid_o    = '0;
      resp_data_o     = dm_resp_data_i;
      resp_op_o       = dm_resp_op_i;
      dm_req_valid_o  = 1'b0;
      dm_resp_ready_o = 1'b0;
      capture         = 1'b0;
      advance         = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (any_valid) begin
               req_ready_o[winner] = 1'b1;
               capture             = 1'b1;
               state_d             = ARB_REQ;
            end
         end
         ARB_REQ: begin
            dm_req_valid_o = 1'b1;
            if (dm_req_ready_i) begin
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            dm_resp_ready_o = resp_ready_i[grant_q];
            if (dm_resp_valid_i) begin
               resp_valid_o[grant_q] = 1'b1;
               if (resp_ready_i[grant_q]) begin
                  state_d = ARB_IDLE;
                  advance = 1'b1;
               end
            end else if (timed_out) begin
               resp_valid_o[grant_q] = 1'b1;
               resp_op_o             = RD_OP_FAILED;
               resp_data_o           = '0;
               if (resp_ready_i[grant_q]) begin
                  state_d = ARB_DRAIN;
               end
            end
         end
         ARB_DRAIN: begin
            dm_resp_ready_o = 1'b1;
            if (dm_resp_valid_i) begin
               state_d = ARB_IDLE;
               advance = 1'b1;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      // Reset holds every handshake low, even the combinational IDLE grant.
      if (trst_i) begin
         req_ready_o     = '0;
         resp_valid_o    = '0;
         resp_data_o     = '0;
         resp_op_o       = '0;
         dm_req_valid_o  = 1'b0;
         dm_resp_ready_o = 1'b0;
         capture         = 1'b0;
         advance         = 1'b0;
      end
   end

   // FSM state and round-robin pointer; the pointer moves past the grant once its transaction retires.
   always_ff @(posedge clk_i or posedge trst_i) begin
      if (trst_i) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         if (advance) begin
            rr_ptr_q <= grant_inc;
         end
      end
   end

   // Capture the winner's payload so the DM sees it stable regardless of the requester.
   always_ff @(posedge clk_i or posedge trst_i) begin
      if (trst_i) begin
         req_q   <= '0;
         grant_q <= '0;
      end else if (capture) begin
         req_q.addr <= req_addr_i[winner];
         req_q.data <= req_data_i[winner];
         req_q.op   <= req_op_i[winner];
         grant_q    <= winner;
      end
   end

   // Response wait counter: cleared entering RESP, saturates at the timeout value.
   always_ff @(posedge clk_i or posedge trst_i) begin
      if (trst_i) begin
         cnt_q <= '0;
      end else if (state_q == ARB_REQ && state_d == ARB_RESP) begin
         cnt_q <= '0;
      end else if (TO_EN && state_q == ARB_RESP && cnt_q != TO_VAL) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_riscv_dmi_arbiter.sv
// Directed bench for riscv_dmi_arbiter with a response scoreboard.
// Latency: checks the one-cycle request path and the 8-cycle timeout.
// Backpressure: exercises DM request stall and requester response stall.
module tb_riscv_dmi_arbiter;
   import riscv_dm_pkg::*;

   localparam int N = 2;

   logic                                  clk_i = 1'b0;
   logic                                  trst_i;
   logic [N-1:0]                          req_valid_i;
   logic [N-1:0]                          req_ready_o;
   logic [N-1:0][DMI_ADDR_WIDTH-1:0]      req_addr_i;
   logic [N-1:0][DMI_DATA_WIDTH-1:0]      req_data_i;
   logic [N-1:0][DMI_OP_WIDTH-1:0]        req_op_i;
   logic [N-1:0]                          resp_valid_o;
   logic [N-1:0]                          resp_ready_i;
   logic [DMI_DATA_WIDTH-1:0]             resp_data_o;
   logic [DMI_OP_WIDTH-1:0]               resp_op_o;
   logic                                  dm_req_valid_o;
   logic                                  dm_req_ready_i;
   logic [DMI_ADDR_WIDTH-1:0]             dm_req_addr_o;
   logic [DMI_DATA_WIDTH-1:0]             dm_req_data_o;
   logic [DMI_OP_WIDTH-1:0]               dm_req_op_o;
   logic                                  dm_resp_valid_i;
   logic                                  dm_resp_ready_o;
   logic [DMI_DATA_WIDTH-1:0]             dm_resp_data_i;
   logic [DMI_OP_WIDTH-1:0]               dm_resp_op_i;
   logic [$clog2(N)-1:0]                  grant_o;
   logic                                  busy_o;

   typedef struct {
      int                         req;
      logic [DMI_DATA_WIDTH-1:0]  data;
      logic [DMI_OP_WIDTH-1:0]    op;
   } exp_t;

   exp_t                      exp_q[$];
   logic [DMI_ADDR_WIDTH-1:0] addr_tab [N];
   int                        passed = 0;
   int                        total  = 0;

   riscv_dmi_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i           (clk_i),
      .trst_i          (trst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr_i),
      .req_data_i      (req_data_i),
      .req_op_i        (req_op_i),
      .resp_valid_o    (resp_valid_o),
      .resp_ready_i    (resp_ready_i),
      .resp_data_o     (resp_data_o),
      .resp_op_o       (resp_op_o),
      .dm_req_valid_o  (dm_req_valid_o),
      .dm_req_ready_i  (dm_req_ready_i),
      .dm_req_addr_o   (dm_req_addr_o),
      .dm_req_data_o   (dm_req_data_o),
      .dm_req_op_o     (dm_req_op_o),
      .dm_resp_valid_i (dm_resp_valid_i),
      .dm_resp_ready_o (dm_resp_ready_o),
      .dm_resp_data_i  (dm_resp_data_i),
      .dm_resp_op_i    (dm_resp_op_i),
      .grant_o         (grant_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Pop the oldest expected response and compare it with what the DUT presents now.
   task automatic expect_resp(input string tag);
      exp_t e;
      chk({tag, "_pending"}, 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_valid"}, 64'(resp_valid_o), 64'(1) << e.req);
         chk({tag, "_data"},  64'(resp_data_o),  64'(e.data));
         chk({tag, "_op"},    64'(resp_op_o),    64'(e.op));
      end
   endtask

   task automatic set_req(input int r, input logic [DMI_ADDR_WIDTH-1:0] a,
                          input logic [DMI_DATA_WIDTH-1:0] d, input logic [DMI_OP_WIDTH-1:0] op);
      addr_tab[r]   = a;
      req_addr_i[r] = a;
      req_data_i[r] = d;
      req_op_i[r]   = op;
   endtask

   // One zero-wait transaction for requester g, entered just after a negedge in IDLE.
   task automatic serve(input int g, input logic [DMI_DATA_WIDTH-1:0] rdata, input bit drop);
      #1;
      chk("idle_ready", 64'(req_ready_o), 64'(1) << g);
      exp_q.push_back('{req: g, data: rdata, op: DTM_SUCCESS});
      @(negedge clk_i);
      if (drop) req_valid_i[g] = 1'b0;
      dm_req_ready_i = 1'b1;
      #1;
      chk("req_valid", 64'(dm_req_valid_o), 64'(1));
      chk("req_addr",  64'(dm_req_addr_o),  64'(addr_tab[g]));
      chk("grant",     64'(grant_o),        64'(g));
      chk("req_stall", 64'(req_ready_o),    64'(0));
      @(negedge clk_i);
      dm_req_ready_i  = 1'b0;
      dm_resp_valid_i = 1'b1;
      dm_resp_data_i  = rdata;
      dm_resp_op_i    = DTM_SUCCESS;
      #1;
      chk("dm_resp_ready", 64'(dm_resp_ready_o), 64'(1));
      expect_resp("resp");
      @(negedge clk_i);
      dm_resp_valid_i = 1'b0;
   endtask

   initial begin
      trst_i          = 1'b1;
      req_valid_i     = '1;
      resp_ready_i    = '1;
      dm_req_ready_i  = 1'b0;
      dm_resp_valid_i = 1'b0;
      dm_resp_data_i  = '0;
      dm_resp_op_i    = '0;
      for (int r = 0; r < N; r++) set_req(r, 7'(r), 32'h0, DTM_READ);

      // Reset state, with both requesters already asserting valid.
      @(negedge clk_i);
      #1;
      chk("rst_req_ready",   64'(req_ready_o),     64'(0));
      chk("rst_resp_valid",  64'(resp_valid_o),    64'(0));
      chk("rst_dm_req_vld",  64'(dm_req_valid_o),  64'(0));
      chk("rst_dm_resp_rdy", 64'(dm_resp_ready_o), 64'(0));
      chk("rst_busy",        64'(busy_o),          64'(0));
      chk("rst_grant",       64'(grant_o),         64'(0));
      chk("rst_dm_addr",     64'(dm_req_addr_o),   64'(0));
      @(negedge clk_i);
      trst_i      = 1'b0;
      req_valid_i = '0;

      // Single read from requester 1.
      set_req(1, 7'h11, 32'h0, DTM_READ);
      req_valid_i = 2'b10;
      serve(1, 32'hDEADBEEF, 1'b1);
      #1;
      chk("single_idle", 64'(busy_o), 64'(0));

      // Both requesters valid from reset: grant alternates 0,1,0,1.
      trst_i = 1'b1;
      @(negedge clk_i);
      trst_i = 1'b0;
      set_req(0, 7'h20, 32'h0, DTM_READ);
      set_req(1, 7'h21, 32'h0, DTM_READ);
      req_valid_i = 2'b11;
      serve(0, 32'h1000_0000, 1'b0);
      serve(1, 32'h1000_0001, 1'b0);
      serve(0, 32'h1000_0002, 1'b0);
      serve(1, 32'h1000_0003, 1'b0);

      // DM request stall for 5 cycles, then response stall for 3 cycles.
      set_req(0, 7'h30, 32'hA5A5_0000, DTM_WRITE);
      #1;
      chk("bp_ready", 64'(req_ready_o), 64'(1));
      exp_q.push_back('{req: 0, data: 32'hCAFE_F00D, op: DTM_SUCCESS});
      @(negedge clk_i);
      req_valid_i[0] = 1'b0;
      req_addr_i[0]  = 7'h7F;
      req_data_i[0]  = 32'h0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_dm_vld",   64'(dm_req_valid_o), 64'(1));
         chk("bp_dm_addr",  64'(dm_req_addr_o),  64'(7'h30));
         chk("bp_dm_data",  64'(dm_req_data_o),  64'(32'hA5A5_0000));
         chk("bp_dm_op",    64'(dm_req_op_o),    64'(DTM_WRITE));
         chk("bp_r1_stall", 64'(req_ready_o),    64'(0));
         @(negedge clk_i);
      end
      dm_req_ready_i = 1'b1;
      @(negedge clk_i);
      dm_req_ready_i  = 1'b0;
      resp_ready_i    = 2'b10;
      dm_resp_valid_i = 1'b1;
      dm_resp_data_i  = 32'hCAFE_F00D;
      dm_resp_op_i    = DTM_SUCCESS;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rbp_dm_rdy",  64'(dm_resp_ready_o), 64'(0));
         chk("rbp_vld",     64'(resp_valid_o),    64'(1));
         chk("rbp_r1_stall",64'(req_ready_o),     64'(0));
         @(negedge clk_i);
      end
      resp_ready_i = 2'b11;
      #1;
      chk("rbp_dm_rdy_up", 64'(dm_resp_ready_o), 64'(1));
      expect_resp("rbp_resp");
      @(negedge clk_i);
      dm_resp_valid_i = 1'b0;
      serve(1, 32'h0BAD_F00D, 1'b1);

      // Timeout: DM accepts the request but never answers.
      set_req(0, 7'h05, 32'h0, DTM_READ);
      req_valid_i = 2'b01;
      #1;
      chk("to_ready", 64'(req_ready_o), 64'(1));
      exp_q.push_back('{req: 0, data: 32'h0, op: RD_OP_FAILED});
      @(negedge clk_i);
      req_valid_i    = '0;
      dm_req_ready_i = 1'b1;
      @(negedge clk_i);
      dm_req_ready_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("to_quiet", 64'(resp_valid_o), 64'(0));
         @(negedge clk_i);
      end
      #1;
      expect_resp("to_fail");
      @(negedge clk_i);
      #1;
      chk("drain_busy",   64'(busy_o),          64'(1));
      chk("drain_dm_rdy", 64'(dm_resp_ready_o), 64'(1));
      dm_resp_valid_i = 1'b1;
      dm_resp_data_i  = 32'h1234_5678;
      #1;
      chk("drain_no_fwd", 64'(resp_valid_o), 64'(0));
      @(negedge clk_i);
      dm_resp_valid_i = 1'b0;
      #1;
      chk("drain_done", 64'(busy_o), 64'(0));

      // Reset in the middle of REQ, then a late DM response, then a normal request.
      set_req(1, 7'h40, 32'h0, DTM_READ);
      req_valid_i = 2'b10;
      #1;
      chk("mr_ready", 64'(req_ready_o), 64'(2));
      @(negedge clk_i);
      #1;
      chk("mr_in_req", 64'(dm_req_valid_o), 64'(1));
      #2;
      trst_i = 1'b1;
      #1;
      chk("mr_dm_vld",     64'(dm_req_valid_o), 64'(0));
      chk("mr_busy",       64'(busy_o),         64'(0));
      chk("mr_req_ready",  64'(req_ready_o),    64'(0));
      chk("mr_resp_valid", 64'(resp_valid_o),   64'(0));
      chk("mr_grant",      64'(grant_o),        64'(0));
      chk("mr_dm_addr",    64'(dm_req_addr_o),  64'(0));
      @(negedge clk_i);
      trst_i          = 1'b0;
      req_valid_i     = '0;
      dm_resp_valid_i = 1'b1;
      #1;
      chk("late_dm_rdy", 64'(dm_resp_ready_o), 64'(0));
      chk("late_vld",    64'(resp_valid_o),    64'(0));
      @(negedge clk_i);
      dm_resp_valid_i = 1'b0;
      set_req(1, 7'h41, 32'h0, DTM_READ);
      req_valid_i = 2'b10;
      serve(1, 32'h600D_CAFE, 1'b1);

      chk("sb_empty", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
